pid_sequencer: RTL and testbench

//  Control-side sequencer for a single pid core. Holds host-written shadow gains and pushes only
//  the changed ones into the core's register port on commit (one per cycle). Paces iterations

---
 rtl/pid_sequencer_pkg.sv | 35 +++
 rtl/pid_sequencer_if.sv | 27 ++
 rtl/pid_sequencer_tick_gen.sv | 26 ++
 rtl/pid_sequencer.sv | 158 +++++++++++++++
 tb/tb_pid_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pid_sequencer_pkg.sv
// Shared widths, gain map, FSM encoding and helpers for the pid control-side sequencer.
package pid_sequencer_pkg;

    localparam int unsigned D_WIDTH   = 16;
    localparam int unsigned Q_BITS    = 13;
    localparam int unsigned N_GAINS   = 4;
    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned TIMEOUT   = 64;

    localparam int unsigned GAIN_AW   = $clog2(N_GAINS);
    localparam int unsigned TO_W      = $clog2(TIMEOUT);

    localparam logic [D_WIDTH-1:0] KP_ADDR = D_WIDTH'(0);
    localparam logic [D_WIDTH-1:0] KI_ADDR = D_WIDTH'(1);
    localparam logic [D_WIDTH-1:0] KD_ADDR = D_WIDTH'(2);
    localparam logic [D_WIDTH-1:0] KF_ADDR = D_WIDTH'(3);

    // Unity gain in the core's fixed-point format.
    localparam logic [D_WIDTH-1:0] GAIN_ONE = D_WIDTH'(1) << Q_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_t;

    // Index of the lowest set bit; the caller guarantees mask != 0.
    function automatic logic [GAIN_AW-1:0] lowest_set(input logic [N_GAINS-1:0] mask);
        lowest_set = '0;
        for (int i = int'(N_GAINS) - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = GAIN_AW'(i);
        end
    endfunction

endpackage

// File: rtl/pid_sequencer_if.sv
// Register/iteration port between the sequencer (master) and the pid core (slave).
interface pid_sequencer_if
    import pid_sequencer_pkg::*;
    ;

    logic               pid_write_enable;
    logic [D_WIDTH-1:0] pid_reg_addr;
    logic [D_WIDTH-1:0] pid_reg_data;
    logic               pid_iterate_enable;
    logic [D_WIDTH-1:0] pid_target;
    logic [D_WIDTH-1:0] pid_measurement;
    logic [D_WIDTH-1:0] pid_out;
    logic               pid_out_valid;

    modport master (
        output pid_write_enable, pid_reg_addr, pid_reg_data,
        output pid_iterate_enable, pid_target, pid_measurement,
        input  pid_out, pid_out_valid
    );

    modport slave (
        input  pid_write_enable, pid_reg_addr, pid_reg_data,
        input  pid_iterate_enable, pid_target, pid_measurement,
        output pid_out, pid_out_valid
    );

endinterface

// File: rtl/pid_sequencer_tick_gen.sv
// Sample-rate prescaler: one registered tick every sample_div+1 cycles while run is high.
module pid_sequencer_tick_gen
    import pid_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] sample_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    // >= keeps the counter bounded if sample_div is lowered mid-count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= run && (cnt >= sample_div);
            if (!run || (cnt >= sample_div)) cnt <= '0;
            else                             cnt <= cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pid_sequencer.sv
// Control-side sequencer for one pid core: shadow gains with dirty push on commit,
// tick-paced iterations, result capture, and sticky overrun/timeout flags.
module pid_sequencer
    import pid_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [D_WIDTH-1:0]   cfg_addr,
    input  logic [D_WIDTH-1:0]   cfg_data,
    input  logic                 cfg_commit,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] sample_div,
    input  logic [D_WIDTH-1:0]   target_in,
    input  logic [D_WIDTH-1:0]   meas_in,
    input  logic                 err_clr,
    pid_sequencer_if.master      pid,
    output logic [D_WIDTH-1:0]   ctrl_out,
    output logic                 ctrl_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err
);

    state_t               state, state_d;
    logic [N_GAINS-1:0]   dirty, dirty_d;
    logic [D_WIDTH-1:0]   shadow [N_GAINS];
    logic                 commit_pending, commit_pending_d;
    logic                 tick_pending, tick_pending_d;
    logic [TO_W-1:0]      to_cnt, to_cnt_d;
    logic                 tick;
    logic                 cfg_hit;
    logic [GAIN_AW-1:0]   cfg_idx;
    logic                 push, latch, capture, ovr_set, to_set;
    logic [GAIN_AW-1:0]   push_idx;

    pid_sequencer_tick_gen u_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .sample_div (sample_div),
        .tick       (tick)
    );

    assign cfg_hit = cfg_we && (cfg_addr < D_WIDTH'(N_GAINS));
    assign cfg_idx = cfg_addr[GAIN_AW-1:0];

    always_comb begin
        state_d          = state;
        dirty_d          = dirty;
        commit_pending_d = commit_pending;
        tick_pending_d   = tick_pending;
        to_cnt_d         = to_cnt;
        push             = 1'b0;
        push_idx         = lowest_set(dirty);
        latch            = 1'b0;
        capture          = 1'b0;
        ovr_set          = 1'b0;
        to_set           = 1'b0;

        case (state)
            IDLE: begin
                if (commit_pending && (dirty != '0)) begin
                    // Loading wins; a coincident tick waits in the one-deep pending slot.
                    state_d = LOAD;
                    push    = 1'b1;
                    if (tick) begin
                        if (tick_pending) ovr_set = 1'b1;
                        else              tick_pending_d = 1'b1;
                    end
                end else begin
                    commit_pending_d = 1'b0;
                    if (tick || tick_pending) begin
                        state_d        = WAIT;
                        latch          = 1'b1;
                        tick_pending_d = 1'b0;
                        to_cnt_d       = '0;
                    end
                end
            end
            LOAD: begin
                if (dirty != '0) begin
                    push = 1'b1;
                end else begin
                    state_d          = IDLE;
                    commit_pending_d = 1'b0;
                end
                if (tick) begin
                    if (tick_pending) ovr_set = 1'b1;
                    else              tick_pending_d = 1'b1;
                end
            end
            WAIT: begin
                if (tick) ovr_set = 1'b1;
                if (pid.pid_out_valid) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    to_set  = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A host write landing on the entry being pushed re-arms it.
        if (push)    dirty_d[push_idx] = 1'b0;
        if (cfg_hit) dirty_d[cfg_idx]  = 1'b1;
        if (cfg_commit && (state != LOAD)) commit_pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            dirty                  <= '0;
            commit_pending         <= 1'b0;
            tick_pending           <= 1'b0;
            to_cnt                 <= '0;
            pid.pid_write_enable   <= 1'b1;
            pid.pid_reg_addr       <= '0;
            pid.pid_reg_data       <= '0;
            pid.pid_iterate_enable <= 1'b0;
            pid.pid_target         <= '0;
            pid.pid_measurement    <= '0;
            ctrl_out               <= '0;
            ctrl_valid             <= 1'b0;
            busy                   <= 1'b0;
            overrun                <= 1'b0;
            timeout_err            <= 1'b0;
            for (int i = 0; i < int'(N_GAINS); i++) shadow[i] <= '0;
        end else begin
            state                  <= state_d;
            dirty                  <= dirty_d;
            commit_pending         <= commit_pending_d;
            tick_pending           <= tick_pending_d;
            to_cnt                 <= to_cnt_d;
            pid.pid_write_enable   <= !push;
            if (push) begin
                pid.pid_reg_addr   <= D_WIDTH'(push_idx);
                pid.pid_reg_data   <= shadow[push_idx];
            end
            pid.pid_iterate_enable <= (state_d == WAIT);
            if (latch) begin
                pid.pid_target      <= target_in;
                pid.pid_measurement <= meas_in;
            end
            ctrl_valid             <= capture;
            if (capture) ctrl_out  <= pid.pid_out;
            busy                   <= (state_d != IDLE);
            overrun                <= ovr_set || (overrun && !err_clr);
            timeout_err            <= to_set  || (timeout_err && !err_clr);
            if (cfg_hit) shadow[cfg_idx] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_pid_sequencer.sv
// Self-checking bench for pid_sequencer with a behavioural pid core and a gain/pacing reference model.
module tb_pid_sequencer;
    import pid_sequencer_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst, cfg_we, cfg_commit, run, err_clr;
    logic [D_WIDTH-1:0]   cfg_addr, cfg_data, target_in, meas_in, ctrl_out;
    logic [DIV_WIDTH-1:0] sample_div;
    logic                 ctrl_valid, busy, overrun, timeout_err;

    pid_sequencer_if bus ();

    pid_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_commit  (cfg_commit),
        .run         (run),
        .sample_div  (sample_div),
        .target_in   (target_in),
        .meas_in     (meas_in),
        .err_clr     (err_clr),
        .pid         (bus),
        .ctrl_out    (ctrl_out),
        .ctrl_valid  (ctrl_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int core_lat = 3;
    int core_cnt = 0;
    int iter_cycles = 0;
    bit core_busy = 1'b0;
    bit iter_prev = 1'b0;
    logic [D_WIDTH-1:0] core_res;
    logic [D_WIDTH-1:0] shadow_m [N_GAINS];
    bit                 dirty_m  [N_GAINS];
    logic [D_WIDTH-1:0] wr_addr_q[$], wr_data_q[$], val_q[$], exp_q[$];
    int                 wr_cyc_q[$], val_cyc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // One clock: observe at edge+1, run the pid core model, then drive fresh setpoints.
    task automatic cyc();
        logic [D_WIDTH-1:0] t_prev, m_prev;
        t_prev = target_in;
        m_prev = meas_in;
        @(posedge clk);
        #1;
        cyc_n++;
        check("we_iter_excl", 32'(!bus.pid_write_enable && bus.pid_iterate_enable), 32'(0));
        if (!bus.pid_write_enable) begin
            wr_addr_q.push_back(bus.pid_reg_addr);
            wr_data_q.push_back(bus.pid_reg_data);
            wr_cyc_q.push_back(cyc_n);
            check("busy_in_load", 32'(busy), 32'(1));
        end
        if (ctrl_valid) begin
            val_q.push_back(ctrl_out);
            val_cyc_q.push_back(cyc_n);
        end
        if (bus.pid_iterate_enable) iter_cycles++;
        bus.pid_out_valid = 1'b0;
        if (!bus.pid_iterate_enable) begin
            core_busy = 1'b0;
        end else if (!iter_prev) begin
            check("target_latch", 32'(bus.pid_target), 32'(t_prev));
            check("meas_latch", 32'(bus.pid_measurement), 32'(m_prev));
            core_busy = 1'b1;
            core_cnt  = 0;
            core_res  = t_prev - m_prev;
        end
        if (core_busy) begin
            if (core_lat >= 0 && core_cnt == core_lat) begin
                bus.pid_out_valid = 1'b1;
                bus.pid_out       = core_res;
                exp_q.push_back(core_res);
                core_busy = 1'b0;
            end else begin
                core_cnt++;
            end
        end
        iter_prev = bus.pid_iterate_enable;
        target_in = D_WIDTH'($urandom);
        meas_in   = D_WIDTH'($urandom);
    endtask

    task automatic cfg_write(input logic [D_WIDTH-1:0] a, input logic [D_WIDTH-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        if (a < D_WIDTH'(N_GAINS)) begin
            shadow_m[a[GAIN_AW-1:0]] = d;
            dirty_m[a[GAIN_AW-1:0]]  = 1'b1;
        end
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic clear_obs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        val_q.delete(); val_cyc_q.delete(); exp_q.delete();
    endtask

    // Commit and expect every dirty gain once, in ascending address order, one per cycle.
    task automatic commit_check(input string tag, input bit chk_lat);
        logic [D_WIDTH-1:0] ea[$], ed[$];
        int c0;
        for (int i = 0; i < int'(N_GAINS); i++) begin
            if (dirty_m[i]) begin
                ea.push_back(D_WIDTH'(i));
                ed.push_back(shadow_m[i]);
                dirty_m[i] = 1'b0;
            end
        end
        clear_obs();
        c0 = cyc_n;
        cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        repeat (12) cyc();
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < wr_addr_q.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(ea[i]));
            check({tag, "_data"}, 32'(wr_data_q[i]), 32'(ed[i]));
            if (chk_lat) check({tag, "_wr_cycle"}, 32'(wr_cyc_q[i]), 32'(c0 + 2 + i));
        end
        check({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    // Free-running iterations; every result must match the core model and arrive on a fixed period.
    task automatic paced(input string tag, input int lat, input int div, input int ncyc,
                         input int period, input bit exp_ovr);
        core_lat   = lat;
        sample_div = DIV_WIDTH'(div);
        clear_obs();
        run = 1'b1;
        repeat (ncyc) cyc();
        run = 1'b0;
        repeat (40) cyc();
        check({tag, "_nvalid"}, 32'(val_q.size()), 32'(exp_q.size()));
        check({tag, "_enough"}, 32'(val_q.size() >= ncyc / period - 1), 32'(1));
        for (int i = 0; i < val_q.size() && i < exp_q.size(); i++)
            check({tag, "_ctrl_out"}, 32'(val_q[i]), 32'(exp_q[i]));
        for (int i = 1; i < val_cyc_q.size(); i++)
            check({tag, "_period"}, 32'(val_cyc_q[i] - val_cyc_q[i-1]), 32'(period));
        check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        int k;
        logic [D_WIDTH-1:0] a, d;
        rst = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; run = 1'b0; err_clr = 1'b0;
        cfg_addr = '0; cfg_data = '0; sample_div = '0;
        target_in = '0; meas_in = '0;
        bus.pid_out = '0; bus.pid_out_valid = 1'b0;
        for (int i = 0; i < int'(N_GAINS); i++) begin shadow_m[i] = '0; dirty_m[i] = 1'b0; end

        cyc(); cyc();
        check("rst_we", 32'(bus.pid_write_enable), 32'(1));
        check("rst_iter", 32'(bus.pid_iterate_enable), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ctrl_valid", 32'(ctrl_valid), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_timeout", 32'(timeout_err), 32'(0));
        check("rst_ctrl_out", 32'(ctrl_out), 32'(0));
        rst = 1'b0;
        cyc();

        cfg_write(KP_ADDR, 16'h0200);
        cfg_write(KI_ADDR, 16'h1000);
        commit_check("gain_load", 1'b1);
        commit_check("dirty_empty", 1'b1);

        // Write to the entry being pushed: it goes out again with the new value.
        cfg_write(KP_ADDR, 16'h1111);
        cfg_write(KI_ADDR, 16'h2222);
        clear_obs();
        cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        cfg_we = 1'b1; cfg_addr = KP_ADDR; cfg_data = 16'h3333;
        cyc();
        cfg_we = 1'b0;
        repeat (10) cyc();
        shadow_m[0] = 16'h3333; dirty_m[0] = 1'b0; dirty_m[1] = 1'b0;
        check("rehit_nwrites", 32'(wr_addr_q.size()), 32'(3));
        if (wr_addr_q.size() == 3) begin
            check("rehit_a0", 32'(wr_addr_q[0]), 32'(0));
            check("rehit_d0", 32'(wr_data_q[0]), 32'(16'h1111));
            check("rehit_a1", 32'(wr_addr_q[1]), 32'(0));
            check("rehit_d1", 32'(wr_data_q[1]), 32'(16'h3333));
            check("rehit_a2", 32'(wr_addr_q[2]), 32'(1));
            check("rehit_d2", 32'(wr_data_q[2]), 32'(16'h2222));
        end

        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++) begin
                case ($urandom_range(0, 5))
                    0:       a = 16'hFFFF;
                    1:       a = D_WIDTH'($urandom_range(4, 7));
                    default: a = D_WIDTH'($urandom_range(0, 3));
                endcase
                d = (j == 0) ? GAIN_ONE : D_WIDTH'($urandom);
                cfg_write(a, d);
            end
            commit_check("rand_load", 1'b1);
        end

        paced("pacing", 3, 9, 120, 10, 1'b0);
        paced("overrun", 15, 9, 200, 20, 1'b1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("ovr_clear", 32'(overrun), 32'(0));

        core_lat = -1;
        clear_obs();
        iter_cycles = 0;
        sample_div = '0;
        run = 1'b1;
        cyc();
        run = 1'b0;
        repeat (100) cyc();
        check("to_wait_cycles", 32'(iter_cycles), 32'(TIMEOUT));
        check("to_flag", 32'(timeout_err), 32'(1));
        check("to_idle", 32'(busy), 32'(0));
        check("to_no_valid", 32'(val_q.size()), 32'(0));
        check("to_no_overrun", 32'(overrun), 32'(0));
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("to_clear", 32'(timeout_err), 32'(0));

        cfg_write(KP_ADDR, 16'h0A0A);
        cfg_write(KI_ADDR, 16'h0B0B);
        cfg_write(KD_ADDR, 16'h0C0C);
        clear_obs();
        cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        k = 0;
        while (bus.pid_write_enable && k < 10) begin cyc(); k++; end
        check("midload_reached", 32'(bus.pid_write_enable), 32'(0));
        rst = 1'b1;
        cyc();
        check("midload_we", 32'(bus.pid_write_enable), 32'(1));
        check("midload_busy", 32'(busy), 32'(0));
        check("midload_one_write", 32'(wr_addr_q.size()), 32'(1));
        rst = 1'b0;
        for (int i = 0; i < int'(N_GAINS); i++) begin shadow_m[i] = '0; dirty_m[i] = 1'b0; end
        repeat (10) cyc();
        cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        repeat (10) cyc();
        check("midload_no_more_writes", 32'(wr_addr_q.size()), 32'(1));

        // Mixed traffic: host writes and commits racing with ticks.
        clear_obs();
        core_lat   = $urandom_range(0, 6);
        sample_div = DIV_WIDTH'($urandom_range(3, 12));
        run = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'b1; cfg_addr = D_WIDTH'($urandom_range(0, 5)); cfg_data = D_WIDTH'($urandom);
            end
            cfg_commit = ($urandom_range(0, 19) == 0);
            cyc();
            cfg_we = 1'b0;
            cfg_commit = 1'b0;
        end
        run = 1'b0;
        repeat (40) cyc();
        cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        repeat (12) cyc();
        check("mix_nvalid", 32'(val_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < val_q.size() && i < exp_q.size(); i++)
            check("mix_ctrl_out", 32'(val_q[i]), 32'(exp_q[i]));
        for (int i = 0; i < wr_addr_q.size(); i++)
            check("mix_addr_range", 32'(wr_addr_q[i] < D_WIDTH'(N_GAINS)), 32'(1));
        clear_obs();
        cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        repeat (12) cyc();
        check("mix_drained", 32'(wr_addr_q.size()), 32'(0));
        check("mix_idle", 32'(busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
